ex_mem_stage: RTL
=================

Name: ex_mem_stage

Overview:
- EX-to-MEM pipeline register for the 16-bit WISC core.
- Captures the ALU result, including RED, PADDSB, shifts and ADD/SUB, together with destination, memory-control and halt information.
- Owns the architectural N/Z/V flag register and updates it per opcode as each instruction commits into MEM.
- Supports stall, flush and halt draining, and drives forwarding taps for the EX operand muxes.

Parameters:
- DW, 16, datapath width of ALU result and store data.
- RW, 4, register index width.

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- stall  in  1  hold all stage registers and flags.
- flush  in  1  insert bubble into MEM on the next edge.
- ex_valid  in  1  EX holds a real instruction.
- ex_opcode  in  4  instruction opcode.
- ex_alu_out  in  DW  ALU result, or address for LW/SW.
- ex_ovfl  in  1  signed overflow from the ALU adder (ADD/SUB only).
- ex_rd  in  RW  destination register.
- ex_reg_wr  in  1  register-file write enable.
- ex_mem_rd  in  1  load.
- ex_mem_wr  in  1  store.
- ex_store_data  in  DW  store data.
- mem_valid  out  1  MEM holds a real instruction.
- mem_alu_out  out  DW  registered ALU result.
- mem_rd  out  RW  registered destination.
- mem_reg_wr  out  1  registered write enable, gated by valid.
- mem_mem_rd  out  1  registered load, gated by valid.
- mem_mem_wr  out  1  registered store, gated by valid.
- mem_store_data  out  DW  registered store data.
- flag_n  out  1  negative flag.
- flag_z  out  1  zero flag.
- flag_v  out  1  overflow flag.
- halted  out  1  core has drained a HLT.
- fwd_valid  out  1  MEM result forwardable (mem_reg_wr & ~mem_mem_rd).

Behaviour:
- Reset (rst_n low, async): all outputs 0. Stage registers, flags and state return to reset immediately, including mid-stall or mid-drain.
- Latency: one cycle. The EX inputs sampled at edge k appear on the mem_* outputs after edge k.
- Capture condition: cap = ex_valid & ~stall & ~flush & (state==RUN).
- Edge priority, highest first:
  1. Reset.
  2. flush: mem_valid<=0 and all mem_* enables <=0; data fields may hold stale values. Flush wins over stall.
  3. stall: all registers hold, flags hold.
  4. Otherwise load from EX. If ~ex_valid, load a bubble (valid=0, enables=0).
- Flag update happens on the capture edge only, by opcode:
  - ADD 0000, SUB 0001: N<=ex_alu_out[15], Z<=(ex_alu_out==0), V<=ex_ovfl.
  - XOR 0010, SLL 0100, SRA 0101, ROR 0110: Z only; N and V hold.
  - RED 0011, PADDSB 0111, LW, SW, LLB, LHB, B, BR, PCS, HLT: no flag change.
  - Bubbles, flushed and stalled instructions never change flags.
- RED results arrive already sign-extended to 16 bits. The stage passes them through unchanged, and the sign bit is never used for flags.
- State machine:
  - RUN: normal operation. A capture with opcode 1111 (HLT) -> DRAIN, with the HLT itself in MEM as valid, reg_wr=0 and mem_wr=0.
  - DRAIN: exactly one cycle, then -> HALTED unless stall is high, in which case stay in DRAIN. Flush in DRAIN still goes to HALTED. EX inputs are ignored.
  - HALTED: mem_valid=0 permanently and halted=1. Only reset exits.
  - A flush on the same edge as a HLT capture means the HLT was not captured; the state stays in RUN.
- fwd_valid is derived combinationally from the registered fields; it is 0 for loads and for bubbles.
- No arithmetic is done here; widths pass straight through with no extension or truncation.

Optional Feature:
- Macro FLAG_BYPASS_EN.
- Defined: flag_n/flag_z/flag_v present next-state values combinationally in the capture cycle, so a BR in EX sees the flags of the ADD/SUB/XOR/shift directly ahead of it without a stall. Reset still forces 0.
- Undefined: flags are register outputs only, visible one cycle after capture; hazard logic must stall a dependent branch one cycle.

Test Plan:
- Reset with rst_n=0 mid-operation (after ADD result 0x8000 captured) -> all outputs 0 immediately, before any clock edge; flags 000.
- ADD, ex_alu_out=0x8000, ex_ovfl=1 -> next cycle mem_alu_out=0x8000, N=1, Z=0, V=1. Then XOR with result 0x0000 -> Z=1, N=1 and V=1 held.
- RED with ex_alu_out=0xFFF3 and flags 001 -> mem_alu_out=0xFFF3, reg_wr=1, flags remain 001.
- stall=1 for 3 cycles with SUB result 0x0000 in EX -> mem_* and flags unchanged; the first edge with stall=0 sets Z=1. With stall=1 and flush=1 together -> mem_valid=0.
- LW into r5 -> mem_mem_rd=1, fwd_valid=0. ADD into r5 -> fwd_valid=1, mem_rd=5.
- HLT captured -> mem_valid=1 for one cycle, then halted=1 and mem_valid=0. A subsequent ADD on the EX inputs leaves mem_valid at 0 and flags unchanged.

Source files
------------

// File: rtl/ex_mem_stage_if.sv
// ============================================================================
// Module   : ex_mem_stage_if
// Purpose  : EX->MEM boundary bundle: EX-side inputs, pipeline control and
//            the registered MEM-side outputs of ex_mem_stage.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface ex_mem_stage_if #(
  parameter int DW = 16,
  parameter int RW = 4
);
  logic          stall;
  logic          flush;
  logic          ex_valid;
  logic [3:0]    ex_opcode;
  logic [DW-1:0] ex_alu_out;
  logic          ex_ovfl;
  logic [RW-1:0] ex_rd;
  logic          ex_reg_wr;
  logic          ex_mem_rd;
  logic          ex_mem_wr;
  logic [DW-1:0] ex_store_data;

  logic          mem_valid;
  logic [DW-1:0] mem_alu_out;
  logic [RW-1:0] mem_rd;
  logic          mem_reg_wr;
  logic          mem_mem_rd;
  logic          mem_mem_wr;
  logic [DW-1:0] mem_store_data;
  logic          flag_n;
  logic          flag_z;
  logic          flag_v;
  logic          halted;
  logic          fwd_valid;

  modport master (
    output stall, flush, ex_valid, ex_opcode, ex_alu_out, ex_ovfl, ex_rd,
           ex_reg_wr, ex_mem_rd, ex_mem_wr, ex_store_data,
    input  mem_valid, mem_alu_out, mem_rd, mem_reg_wr, mem_mem_rd, mem_mem_wr,
           mem_store_data, flag_n, flag_z, flag_v, halted, fwd_valid
  );

  modport slave (
    input  stall, flush, ex_valid, ex_opcode, ex_alu_out, ex_ovfl, ex_rd,
           ex_reg_wr, ex_mem_rd, ex_mem_wr, ex_store_data,
    output mem_valid, mem_alu_out, mem_rd, mem_reg_wr, mem_mem_rd, mem_mem_wr,
           mem_store_data, flag_n, flag_z, flag_v, halted, fwd_valid
  );
endinterface

`default_nettype wire

// File: rtl/ex_mem_stage.sv
// ============================================================================
// Module   : ex_mem_stage
// Purpose  : WISC EX->MEM pipeline register with N/Z/V flag ownership,
//            HLT drain FSM and forwarding tap. FLAG_BYPASS_EN exposes the
//            flag next-state combinationally in the capture cycle.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module ex_mem_stage #(
  parameter int DW = 16,
  parameter int RW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  ex_mem_stage_if.slave bus
);

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_DRAIN  = 2'd1,
    S_HALTED = 2'd2
  } state_e;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_XOR = 4'b0010;
  localparam logic [3:0] OP_SLL = 4'b0100;
  localparam logic [3:0] OP_SRA = 4'b0101;
  localparam logic [3:0] OP_ROR = 4'b0110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  state_e        state_q, state_d;
  logic          valid_q, valid_d;
  logic [DW-1:0] alu_q, alu_d;
  logic [RW-1:0] rd_q, rd_d;
  logic          reg_wr_q, reg_wr_d;
  logic          mem_rd_q, mem_rd_d;
  logic          mem_wr_q, mem_wr_d;
  logic [DW-1:0] store_q, store_d;
  logic          n_q, n_d;
  logic          z_q, z_d;
  logic          v_q, v_d;
  logic          cap;
  logic          is_hlt;

  always_comb begin
    cap      = bus.ex_valid & ~bus.stall & ~bus.flush & (state_q == S_RUN);
    is_hlt   = (bus.ex_opcode == OP_HLT);
    state_d  = state_q;
    valid_d  = valid_q;
    alu_d    = alu_q;
    rd_d     = rd_q;
    reg_wr_d = reg_wr_q;
    mem_rd_d = mem_rd_q;
    mem_wr_d = mem_wr_q;
    store_d  = store_q;
    n_d      = n_q;
    z_d      = z_q;
    v_d      = v_q;

    // Flush beats stall; data fields are left stale on a flush.
    if (bus.flush) begin
      valid_d  = 1'b0;
      reg_wr_d = 1'b0;
      mem_rd_d = 1'b0;
      mem_wr_d = 1'b0;
    end else if (!bus.stall) begin
      alu_d    = bus.ex_alu_out;
      rd_d     = bus.ex_rd;
      store_d  = bus.ex_store_data;
      valid_d  = cap;
      reg_wr_d = cap & bus.ex_reg_wr & ~is_hlt;
      mem_rd_d = cap & bus.ex_mem_rd;
      mem_wr_d = cap & bus.ex_mem_wr & ~is_hlt;
    end

    if (cap) begin
      unique case (bus.ex_opcode)
        OP_ADD, OP_SUB: begin
          n_d = bus.ex_alu_out[DW-1];
          z_d = (bus.ex_alu_out == '0);
          v_d = bus.ex_ovfl;
        end
        OP_XOR, OP_SLL, OP_SRA, OP_ROR: z_d = (bus.ex_alu_out == '0);
        default: ;
      endcase
    end

    unique case (state_q)
      S_RUN:    if (cap && is_hlt) state_d = S_DRAIN;
      S_DRAIN:  if (bus.flush || !bus.stall) state_d = S_HALTED;
      S_HALTED: state_d = S_HALTED;
      default:  state_d = S_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_RUN;
      valid_q  <= 1'b0;
      alu_q    <= '0;
      rd_q     <= '0;
      reg_wr_q <= 1'b0;
      mem_rd_q <= 1'b0;
      mem_wr_q <= 1'b0;
      store_q  <= '0;
      n_q      <= 1'b0;
      z_q      <= 1'b0;
      v_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      valid_q  <= valid_d;
      alu_q    <= alu_d;
      rd_q     <= rd_d;
      reg_wr_q <= reg_wr_d;
      mem_rd_q <= mem_rd_d;
      mem_wr_q <= mem_wr_d;
      store_q  <= store_d;
      n_q      <= n_d;
      z_q      <= z_d;
      v_q      <= v_d;
    end
  end

  assign bus.mem_valid      = valid_q;
  assign bus.mem_alu_out    = alu_q;
  assign bus.mem_rd         = rd_q;
  assign bus.mem_reg_wr     = reg_wr_q;
  assign bus.mem_mem_rd     = mem_rd_q;
  assign bus.mem_mem_wr     = mem_wr_q;
  assign bus.mem_store_data = store_q;
  assign bus.halted         = (state_q == S_HALTED);
  assign bus.fwd_valid      = reg_wr_q & ~mem_rd_q;

`ifdef FLAG_BYPASS_EN
  // Next-state view lets a branch in EX see flags of the instruction ahead.
  assign bus.flag_n = rst_n & n_d;
  assign bus.flag_z = rst_n & z_d;
  assign bus.flag_v = rst_n & v_d;
`else
  assign bus.flag_n = n_q;
  assign bus.flag_z = z_q;
  assign bus.flag_v = v_q;
`endif

endmodule

`default_nettype wire
